// File: rtl/nibmul_pipe_arbiter.sv
// Two-requester round-robin front end feeding a two-stage add / nibble-multiply
// pipeline with valid/ready stall control and per-requester result counters.
module nibmul_pipe_arbiter #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic              res_id,
    input  logic              res_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  done_cnt0,
    output logic [CNT_W-1:0]  done_cnt1
);

    typedef enum logic {
        ID_REQ0 = 1'b0,
        ID_REQ1 = 1'b1
    } req_id_e;

    logic              v1;
    logic              v2;
    req_id_e           id1;
    req_id_e           id2;
    req_id_e           last_id;
    logic [DATA_W-1:0] p1;
    logic [DATA_W-1:0] p2;

    logic              s1_en;
    logic              s2_en;
    logic              grant_valid;
    req_id_e           grant_id;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;

    // Low nibble times high nibble, zero-extended back to the full byte.
    function automatic logic [DATA_W-1:0] nib_mul(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] lo;
        logic [DATA_W-1:0] hi;
        lo = '0;
        hi = '0;
        lo[3:0] = x[3:0];
        hi[3:0] = x[7:4];
        return lo * hi;
    endfunction

    assign s2_en = !v2 || res_ready;
    assign s1_en = !v1 || s2_en;

    // rst_n gates the grant so both readies stay low throughout reset.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = ID_REQ0;
        if (rst_n && s1_en && !hold) begin
            unique case ({req1_valid, req0_valid})
                2'b01: begin
                    grant_valid = 1'b1;
                    grant_id    = ID_REQ0;
                end
                2'b10: begin
                    grant_valid = 1'b1;
                    grant_id    = ID_REQ1;
                end
                2'b11: begin
                    grant_valid = 1'b1;
                    grant_id    = (last_id == ID_REQ0) ? ID_REQ1 : ID_REQ0;
                end
                default: begin
                    grant_valid = 1'b0;
                    grant_id    = ID_REQ0;
                end
            endcase
        end
    end

    always_comb begin
        sel_a = req0_a;
        sel_b = req0_b;
        if (grant_id == ID_REQ1) begin
            sel_a = req1_a;
            sel_b = req1_b;
        end
    end

    assign req0_ready = grant_valid && (grant_id == ID_REQ0);
    assign req1_ready = grant_valid && (grant_id == ID_REQ1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            id1     <= ID_REQ0;
            p1      <= '0;
            last_id <= ID_REQ1;
        end else if (s1_en) begin
            v1 <= grant_valid;
            if (grant_valid) begin
                id1     <= grant_id;
                p1      <= sel_a + sel_b;
                last_id <= grant_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2  <= 1'b0;
            id2 <= ID_REQ0;
            p2  <= '0;
        end else if (s2_en) begin
            v2  <= v1;
            id2 <= id1;
            p2  <= nib_mul(p1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt0 <= '0;
            done_cnt1 <= '0;
        end else if (v2 && res_ready) begin
            if (id2 == ID_REQ0) begin
                done_cnt0 <= done_cnt0 + CNT_W'(1);
            end else begin
                done_cnt1 <= done_cnt1 + CNT_W'(1);
            end
        end
    end

    assign res_valid = v2;
    assign res_id    = id2;
    assign res_data  = nib_mul(p2);
    assign busy      = v1 || v2;

endmodule

// File: tb/tb_nibmul_pipe_arbiter.sv
// Directed self-checking bench for nibmul_pipe_arbiter.
module tb_nibmul_pipe_arbiter;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic        req0_valid;
    logic [7:0]  req0_a;
    logic [7:0]  req0_b;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_a;
    logic [7:0]  req1_b;
    logic        req1_ready;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_id;
    logic        res_ready;
    logic        busy;
    logic [15:0] done_cnt0;
    logic [15:0] done_cnt1;

    int compared;
    int mismatched;

    nibmul_pipe_arbiter #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
        .busy(busy), .done_cnt0(done_cnt0), .done_cnt1(done_cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; hold = 1'b0; res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34;
        req1_valid = 1'b1; req1_a = 8'h00; req1_b = 8'h00;
        #3;
        compared++; if (res_valid !== 1'b0) begin mismatched++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
        compared++; if ({req0_ready, req1_ready} !== 2'b00) begin mismatched++; $display("FAIL reset_readies: got %b want 00", {req0_ready, req1_ready}); end
        compared++; if ({done_cnt0, done_cnt1} !== 32'h0) begin mismatched++; $display("FAIL reset_counters: got %h/%h want 0/0", done_cnt0, done_cnt1); end
        step;
        step;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_held_busy: got %b want 0", busy); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_single;
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; res_ready = 1'b1;
        #1;
        compared++; if (req0_ready !== 1'b1) begin mismatched++; $display("FAIL single_ready: got %b want 1", req0_ready); end
        step;
        req0_valid = 1'b0;
        #1;
        compared++; if ({res_valid, busy} !== 2'b01) begin mismatched++; $display("FAIL single_s1: got valid/busy %b want 01", {res_valid, busy}); end
        step;
        compared++; if (res_valid !== 1'b1) begin mismatched++; $display("FAIL single_valid: got %b want 1", res_valid); end
        compared++; if (res_data !== 8'h08) begin mismatched++; $display("FAIL single_data: got %h want 08", res_data); end
        compared++; if (res_id !== 1'b0) begin mismatched++; $display("FAIL single_id: got %b want 0", res_id); end
        step;
        compared++; if (done_cnt0 !== 16'd1) begin mismatched++; $display("FAIL single_cnt0: got %0d want 1", done_cnt0); end
        compared++; if ({res_valid, busy} !== 2'b00) begin mismatched++; $display("FAIL single_drain: got valid/busy %b want 00", {res_valid, busy}); end
    endtask

    task automatic test_wrap;
        req1_valid = 1'b1; req1_a = 8'hFF; req1_b = 8'h02;
        #1;
        compared++; if (req1_ready !== 1'b1) begin mismatched++; $display("FAIL wrap_ready1: got %b want 1", req1_ready); end
        step;
        req1_a = 8'hFF; req1_b = 8'h00;
        #1;
        compared++; if (req1_ready !== 1'b1) begin mismatched++; $display("FAIL wrap_ready2: got %b want 1", req1_ready); end
        step;
        req1_valid = 1'b0;
        #1;
        compared++; if ({res_valid, res_id, res_data} !== {2'b11, 8'h00}) begin mismatched++; $display("FAIL wrap_first: got v/id/data %b/%b/%h want 1/1/00", res_valid, res_id, res_data); end
        step;
        compared++; if (dut.p2 !== 8'hE1) begin mismatched++; $display("FAIL wrap_p2: got %h want e1", dut.p2); end
        compared++; if ({res_valid, res_id, res_data} !== {2'b11, 8'h0E}) begin mismatched++; $display("FAIL wrap_second: got v/id/data %b/%b/%h want 1/1/0e", res_valid, res_id, res_data); end
        step;
        compared++; if (done_cnt1 !== 16'd2) begin mismatched++; $display("FAIL wrap_cnt1: got %0d want 2", done_cnt1); end
    endtask

    task automatic test_contention;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req0_a = 8'h30; req0_b = 8'h07; req1_a = 8'h30; req1_b = 8'h07; res_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            req0_valid = (c < 4);
            req1_valid = (c < 4);
            #1;
            if (c < 4) begin
                compared++; if ({req1_ready, req0_ready} !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin mismatched++; $display("FAIL contention_grant%0d: got r1r0=%b want %b", c, {req1_ready, req0_ready}, (c % 2 == 0) ? 2'b01 : 2'b10); end
            end else begin
                compared++; if ({req1_ready, req0_ready} !== 2'b00) begin mismatched++; $display("FAIL contention_idle%0d: got r1r0=%b want 00", c, {req1_ready, req0_ready}); end
            end
            if (c >= 2) begin
                compared++; if ({res_valid, res_id, res_data} !== {1'b1, ((c - 2) % 2 == 1), 8'h05}) begin mismatched++; $display("FAIL contention_res%0d: got v/id/data %b/%b/%h want 1/%0d/05", c, res_valid, res_id, res_data, (c - 2) % 2); end
            end
            step;
        end
        compared++; if ({done_cnt0, done_cnt1} !== {16'd2, 16'd2}) begin mismatched++; $display("FAIL contention_counts: got %0d/%0d want 2/2", done_cnt0, done_cnt1); end
    endtask

    task automatic test_backpressure;
        int accepted;
        logic [7:0] stream_a [2];
        stream_a[0] = 8'h46;
        stream_a[1] = 8'h37;
        accepted = 0;
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_b = 8'h00;
        for (int c = 0; c < 5; c++) begin
            req0_a = stream_a[accepted % 2];
            #1;
            if (req0_ready === 1'b1) accepted++;
            step;
        end
        compared++; if (accepted != 2) begin mismatched++; $display("FAIL bp_accepted: got %0d want 2", accepted); end
        compared++; if (req0_ready !== 1'b0) begin mismatched++; $display("FAIL bp_stalled_ready: got %b want 0", req0_ready); end
        compared++; if ({res_valid, res_data} !== {1'b1, 8'h08}) begin mismatched++; $display("FAIL bp_stalled_out: got v/data %b/%h want 1/08", res_valid, res_data); end
        req0_valid = 1'b0;
        res_ready = 1'b1;
        #1;
        compared++; if ({res_valid, res_id, res_data} !== {2'b10, 8'h08}) begin mismatched++; $display("FAIL bp_first: got v/id/data %b/%b/%h want 1/0/08", res_valid, res_id, res_data); end
        step;
        compared++; if ({res_valid, res_id, res_data} !== {2'b10, 8'h05}) begin mismatched++; $display("FAIL bp_second: got v/id/data %b/%b/%h want 1/0/05", res_valid, res_id, res_data); end
        step;
        compared++; if ({res_valid, busy} !== 2'b00) begin mismatched++; $display("FAIL bp_drain: got valid/busy %b want 00", {res_valid, busy}); end
        compared++; if (done_cnt0 !== 16'd4) begin mismatched++; $display("FAIL bp_cnt0: got %0d want 4", done_cnt0); end
    endtask

    task automatic test_hold;
        req0_a = 8'h12; req0_b = 8'h34; req1_a = 8'hFF; req1_b = 8'h00;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1; hold = 1'b0;
        #1;
        compared++; if ({req1_ready, req0_ready} !== 2'b10) begin mismatched++; $display("FAIL hold_grant_a: got r1r0=%b want 10", {req1_ready, req0_ready}); end
        step;
        compared++; if ({req1_ready, req0_ready} !== 2'b01) begin mismatched++; $display("FAIL hold_grant_b: got r1r0=%b want 01", {req1_ready, req0_ready}); end
        step;
        hold = 1'b1;
        #1;
        compared++; if ({req1_ready, req0_ready} !== 2'b00) begin mismatched++; $display("FAIL hold_ready_c2: got r1r0=%b want 00", {req1_ready, req0_ready}); end
        compared++; if ({res_valid, res_id, res_data} !== {2'b11, 8'h0E}) begin mismatched++; $display("FAIL hold_res1: got v/id/data %b/%b/%h want 1/1/0e", res_valid, res_id, res_data); end
        step;
        compared++; if ({req1_ready, req0_ready} !== 2'b00) begin mismatched++; $display("FAIL hold_ready_c3: got r1r0=%b want 00", {req1_ready, req0_ready}); end
        compared++; if ({res_valid, res_id, res_data} !== {2'b10, 8'h08}) begin mismatched++; $display("FAIL hold_res2: got v/id/data %b/%b/%h want 1/0/08", res_valid, res_id, res_data); end
        step;
        compared++; if ({busy, res_valid, req1_ready, req0_ready} !== 4'b0000) begin mismatched++; $display("FAIL hold_idle: got busy/v/r1/r0 %b want 0000", {busy, res_valid, req1_ready, req0_ready}); end
        hold = 1'b0;
        #1;
        compared++; if ({req1_ready, req0_ready} !== 2'b10) begin mismatched++; $display("FAIL hold_resume: got r1r0=%b want 10", {req1_ready, req0_ready}); end
        step;
        req0_valid = 1'b0; req1_valid = 1'b0;
        step;
        compared++; if ({res_valid, res_id, res_data} !== {2'b11, 8'h0E}) begin mismatched++; $display("FAIL hold_resume_res: got v/id/data %b/%b/%h want 1/1/0e", res_valid, res_id, res_data); end
        step;
    endtask

    task automatic test_reset_mid;
        req0_a = 8'h12; req0_b = 8'h34; req1_a = 8'h30; req1_b = 8'h07;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b0;
        step;
        step;
        compared++; if ({dut.v1, dut.v2, busy, res_valid} !== 4'b1111) begin mismatched++; $display("FAIL mid_full: got v1/v2/busy/valid %b want 1111", {dut.v1, dut.v2, busy, res_valid}); end
        rst_n = 1'b0;
        #1;
        compared++; if ({res_valid, busy} !== 2'b00) begin mismatched++; $display("FAIL mid_drop: got valid/busy %b want 00", {res_valid, busy}); end
        compared++; if ({done_cnt0, done_cnt1} !== 32'h0) begin mismatched++; $display("FAIL mid_counters: got %0d/%0d want 0/0", done_cnt0, done_cnt1); end
        compared++; if ({req1_ready, req0_ready} !== 2'b00) begin mismatched++; $display("FAIL mid_readies: got r1r0=%b want 00", {req1_ready, req0_ready}); end
        rst_n = 1'b1;
        res_ready = 1'b1;
        #1;
        compared++; if ({req1_ready, req0_ready} !== 2'b01) begin mismatched++; $display("FAIL mid_first_grant: got r1r0=%b want 01", {req1_ready, req0_ready}); end
        step;
        req0_valid = 1'b0; req1_valid = 1'b0;
        step;
        compared++; if ({res_valid, res_id, res_data} !== {2'b10, 8'h08}) begin mismatched++; $display("FAIL mid_after_res: got v/id/data %b/%b/%h want 1/0/08", res_valid, res_id, res_data); end
        step;
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        test_reset;
        test_single;
        test_wrap;
        test_contention;
        test_backpressure;
        test_hold;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
